acq_sequencer: RTL and testbench

- Central measurement sequencer for one acquisition shot.
- On a start request it runs: coil charge (ON_32 low), bipolar EMA burst (EMA_PULSE_P / EMA_PULSE_N), then ADC capture into the sample buffer.
- It then raises a data-ready flag for the FSMC readout path and waits for that path to report readout complete.
- Sits between the synchronised START_FPGA edge detector and the sample buffer / FSMC read logic, all in the 80 MHz domain.

---
 rtl/acq_sequencer_pkg.sv | 23 ++
 rtl/acq_sequencer_if.sv | 46 ++++
 rtl/acq_sequencer_ema_burst_gen.sv | 73 +++++++
 rtl/acq_sequencer.sv | 139 +++++++++++++
 tb/tb_acq_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/acq_sequencer_pkg.sv
// Shared state encoding, driver polarities and burst-length helper for the
// acquisition sequencer and its EMA burst generator.
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        FIRE   = 3'd2,
        ACQ    = 3'd3,
        READY  = 3'd4
    } state_t;

    // EMA drivers and the charge enable are all active low.
    localparam logic DRIVE_ON  = 1'b0;
    localparam logic DRIVE_OFF = 1'b1;

    localparam int PERIOD_W = 4;

    function automatic int pulse_len(input int periods, input int half, input int gap);
        return periods * 2 * half + (periods - 1) * gap;
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Handshake and driver signals between the acquisition sequencer and the
// coil drivers, sample buffer and FSMC readout logic.
interface acq_sequencer_if #(
    parameter int ADDR_W = 13
);
    logic              start;
    logic              abort;
    logic              rd_done;
    logic              ema_pulse_p;
    logic              ema_pulse_n;
    logic              on_32;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic              data_ready;
    logic              busy;
    logic              start_ignored;

    modport master (
        input  start,
        input  abort,
        input  rd_done,
        output ema_pulse_p,
        output ema_pulse_n,
        output on_32,
        output cap_we,
        output cap_addr,
        output data_ready,
        output busy,
        output start_ignored
    );

    modport slave (
        output start,
        output abort,
        output rd_done,
        input  ema_pulse_p,
        input  ema_pulse_n,
        input  on_32,
        input  cap_we,
        input  cap_addr,
        input  data_ready,
        input  busy,
        input  start_ignored
    );

endinterface

// File: rtl/acq_sequencer_ema_burst_gen.sv
// Bipolar EMA burst generator: on fire_start emits NUM_PERIODS periods of
// P-low, N-low, gap, with registered active-low outputs.
module ema_burst_gen
    import acq_pkg::*;
#(
    parameter int PULSE_HALF  = 10,
    parameter int PULSE_GAP   = 3,
    parameter int NUM_PERIODS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fire_start,
    input  logic kill,
    output logic pulse_p,
    output logic pulse_n,
    output logic done
);

    localparam int PERIOD_LEN = 2 * PULSE_HALF + PULSE_GAP;
    localparam int POS_W      = $clog2(PERIOD_LEN + 1);

    localparam logic [POS_W-1:0]    HALF_POS = POS_W'(PULSE_HALF);
    localparam logic [POS_W-1:0]    N_END    = POS_W'(2 * PULSE_HALF - 1);
    localparam logic [POS_W-1:0]    WRAP_POS = POS_W'(PERIOD_LEN - 1);
    localparam logic [PERIOD_W-1:0] LAST_PER = PERIOD_W'(NUM_PERIODS - 1);

    logic                active;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    pos_nxt;
    logic [PERIOD_W-1:0] per;

    // The final period has no trailing gap, so the burst ends on its last N cycle.
    assign done = active && (per == LAST_PER) && (pos == N_END);

    always_comb begin
        pos_nxt = pos + POS_W'(1);
        if (pos == WRAP_POS) begin
            pos_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            active  <= 1'b0;
            pos     <= '0;
            per     <= '0;
            pulse_p <= DRIVE_OFF;
            pulse_n <= DRIVE_OFF;
        end else if (fire_start) begin
            active  <= 1'b1;
            pos     <= '0;
            per     <= '0;
            pulse_p <= DRIVE_ON;
            pulse_n <= DRIVE_OFF;
        end else if (active) begin
            if (done) begin
                active  <= 1'b0;
                pos     <= '0;
                per     <= '0;
                pulse_p <= DRIVE_OFF;
                pulse_n <= DRIVE_OFF;
            end else begin
                pos <= pos_nxt;
                if (pos == WRAP_POS) begin
                    per <= per + PERIOD_W'(1);
                end
                pulse_p <= (pos_nxt < HALF_POS) ? DRIVE_ON : DRIVE_OFF;
                pulse_n <= ((pos_nxt >= HALF_POS) && (pos_nxt <= N_END)) ? DRIVE_ON : DRIVE_OFF;
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition shot sequencer: coil charge, EMA burst, ADC capture into the
// sample buffer, then data-ready handshake with the FSMC reader.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CHARGE_CYCLES = 6400000,
    parameter int PULSE_HALF    = 10,
    parameter int PULSE_GAP     = 3,
    parameter int NUM_PERIODS   = 2,
    parameter int SAMPLES       = 5000,
    parameter int CNT_W         = 24,
    parameter int ADDR_W        = 13
) (
    input logic            clk_80mhz,
    input logic            rst,
    acq_sequencer_if.master bus
);

    localparam int PULSE_LEN = pulse_len(NUM_PERIODS, PULSE_HALF, PULSE_GAP);

    localparam logic [CNT_W-1:0]  CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] SAMPLE_LAST = ADDR_W'(SAMPLES - 1);

    generate
        if (SAMPLES <= PULSE_LEN || SAMPLES > 2 ** ADDR_W) begin : g_bad_samples
            $fatal(1, "acq_sequencer: SAMPLES must exceed the burst length and fit the buffer");
        end
        if (NUM_PERIODS < 1 || NUM_PERIODS > 15) begin : g_bad_periods
            $fatal(1, "acq_sequencer: NUM_PERIODS must be 1..15");
        end
        if (CHARGE_CYCLES < 1 || CHARGE_CYCLES > 2 ** CNT_W) begin : g_bad_charge
            $fatal(1, "acq_sequencer: CHARGE_CYCLES must be 1..2**CNT_W");
        end
    endgenerate

    state_t            state;
    logic [CNT_W-1:0]  charge_cnt;
    logic [ADDR_W-1:0] sample_cnt;
    logic              on_32;
    logic              cap_we;
    logic              data_ready;
    logic              busy;
    logic              start_ignored;
    logic              fire_start;
    logic              burst_p;
    logic              burst_n;
    logic              burst_done;

    // Launch the burst so its first P-low cycle coincides with the first capture.
    assign fire_start = (state == CHARGE) && (charge_cnt == CHARGE_LAST);

    ema_burst_gen #(
        .PULSE_HALF  (PULSE_HALF),
        .PULSE_GAP   (PULSE_GAP),
        .NUM_PERIODS (NUM_PERIODS)
    ) u_burst (
        .clk        (clk_80mhz),
        .rst        (rst),
        .fire_start (fire_start),
        .kill       (bus.abort),
        .pulse_p    (burst_p),
        .pulse_n    (burst_n),
        .done       (burst_done)
    );

    // Capture runs alongside the burst; FIRE only tracks when the coil may be released.
    always_ff @(posedge clk_80mhz) begin
        if (rst || bus.abort) begin
            state         <= IDLE;
            charge_cnt    <= '0;
            sample_cnt    <= '0;
            on_32         <= DRIVE_OFF;
            cap_we        <= 1'b0;
            data_ready    <= 1'b0;
            busy          <= 1'b0;
            start_ignored <= 1'b0;
        end else begin
            start_ignored <= bus.start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= CHARGE;
                        charge_cnt <= '0;
                        on_32      <= DRIVE_ON;
                        busy       <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (charge_cnt == CHARGE_LAST) begin
                        state      <= FIRE;
                        charge_cnt <= '0;
                        sample_cnt <= '0;
                        cap_we     <= 1'b1;
                    end else begin
                        charge_cnt <= charge_cnt + CNT_W'(1);
                    end
                end
                FIRE: begin
                    sample_cnt <= sample_cnt + ADDR_W'(1);
                    if (burst_done) begin
                        state <= ACQ;
                        on_32 <= DRIVE_OFF;
                    end
                end
                ACQ: begin
                    if (sample_cnt == SAMPLE_LAST) begin
                        state      <= READY;
                        sample_cnt <= '0;
                        cap_we     <= 1'b0;
                        data_ready <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (bus.rd_done) begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ema_pulse_p   = burst_p;
    assign bus.ema_pulse_n   = burst_n;
    assign bus.on_32         = on_32;
    assign bus.cap_we        = cap_we;
    assign bus.cap_addr      = sample_cnt;
    assign bus.data_ready    = data_ready;
    assign bus.busy          = busy;
    assign bus.start_ignored = start_ignored;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a short charge (100) and 64 samples:
// a cycle-indexed vector table plus hand-written reset and handshake sequences.
module tb_acq_sequencer;

    localparam int ADDR_W = 13;

    typedef struct packed {
        logic              p;
        logic              n;
        logic              on;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              dr;
        logic              busy;
        logic              si;
    } out_t;

    typedef struct {
        int    cyc;
        logic  start;
        logic  abort;
        logic  rd_done;
        logic  chk;
        string name;
        out_t  exp;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    vec_t vecs[$];

    acq_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    acq_sequencer #(
        .CHARGE_CYCLES (100),
        .PULSE_HALF    (10),
        .PULSE_GAP     (3),
        .NUM_PERIODS   (2),
        .SAMPLES       (64),
        .CNT_W         (24),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk_80mhz (clk),
        .rst       (rst),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic p, input logic n, input logic on, input logic we,
                                input int addr, input logic dr, input logic bs, input logic si);
        mk = '{p, n, on, we, ADDR_W'(addr), dr, bs, si};
    endfunction

    function automatic out_t sample_out();
        sample_out = '{bus.ema_pulse_p, bus.ema_pulse_n, bus.on_32, bus.cap_we,
                       bus.cap_addr, bus.data_ready, bus.busy, bus.start_ignored};
    endfunction

    task automatic add_stim(input int c, input logic s, input logic a, input logic d);
        vecs.push_back('{c, s, a, d, 1'b0, "", '0});
    endtask

    task automatic add_chk(input int c, input string nm, input out_t e);
        vecs.push_back('{c, 1'b0, 1'b0, 1'b0, 1'b1, nm, e});
    endtask

    // Advance to the next cycle, drive inputs for it, and stop at its negedge.
    task automatic next_cycle(input logic s, input logic a, input logic d, input logic r);
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        bus.start   = s;
        bus.abort   = a;
        bus.rd_done = d;
        rst         = r;
        @(negedge clk);
    endtask

    task automatic check_vec(input string nm, input out_t e);
        out_t a;
        a = sample_out();
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s @%0d: got p=%b n=%b on=%b we=%b addr=%0d dr=%b busy=%b si=%b, want p=%b n=%b on=%b we=%b addr=%0d dr=%b busy=%b si=%b",
                     nm, cyc, a.p, a.n, a.on, a.we, a.addr, a.dr, a.busy, a.si,
                     e.p, e.n, e.on, e.we, e.addr, e.dr, e.busy, e.si);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int e);
        total++;
        if (act != e) begin
            bad++;
            $display("[TB] FAIL %s @%0d: got %0d, want %0d", nm, cyc, act, e);
        end
    endtask

    task automatic apply_stimulus(input int c);
        logic s;
        logic a;
        logic d;
        s = 1'b0;
        a = 1'b0;
        d = 1'b0;
        foreach (vecs[i]) begin
            if (!vecs[i].chk && vecs[i].cyc == c) begin
                s = s | vecs[i].start;
                a = a | vecs[i].abort;
                d = d | vecs[i].rd_done;
            end
        end
        next_cycle(s, a, d, (c < 5));
    endtask

    task automatic check_output(input int c);
        foreach (vecs[i]) begin
            if (vecs[i].chk && vecs[i].cyc == c) begin
                check_vec(vecs[i].name, vecs[i].exp);
            end
        end
    endtask

    initial begin
        int s0;
        int s2;
        int n;
        out_t idle;

        total       = 0;
        bad         = 0;
        cyc         = -1;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.rd_done = 1'b0;
        idle        = mk(1, 1, 1, 0, 0, 0, 0, 0);

        // Shot 1 starts at 10 (F=111); shot 2 at 302 (F=403) is aborted mid-P.
        add_stim(10, 1, 0, 0);
        add_stim(50, 1, 0, 0);
        add_stim(100, 0, 0, 1);
        add_stim(300, 0, 0, 1);
        add_stim(302, 1, 0, 0);
        add_stim(407, 0, 1, 0);
        add_stim(409, 1, 1, 0);

        add_chk(2,   "reset",        idle);
        add_chk(10,  "idle",         idle);
        add_chk(11,  "charge",       mk(1, 1, 0, 0, 0,  0, 1, 0));
        add_chk(51,  "ign_pulse",    mk(1, 1, 0, 0, 0,  0, 1, 1));
        add_chk(52,  "ign_end",      mk(1, 1, 0, 0, 0,  0, 1, 0));
        add_chk(101, "rd_ignored",   mk(1, 1, 0, 0, 0,  0, 1, 0));
        add_chk(110, "pre_fire",     mk(1, 1, 0, 0, 0,  0, 1, 0));
        add_chk(111, "p0_start",     mk(0, 1, 0, 1, 0,  0, 1, 0));
        add_chk(120, "p0_end",       mk(0, 1, 0, 1, 9,  0, 1, 0));
        add_chk(121, "n0_start",     mk(1, 0, 0, 1, 10, 0, 1, 0));
        add_chk(130, "n0_end",       mk(1, 0, 0, 1, 19, 0, 1, 0));
        add_chk(131, "gap_start",    mk(1, 1, 0, 1, 20, 0, 1, 0));
        add_chk(133, "gap_end",      mk(1, 1, 0, 1, 22, 0, 1, 0));
        add_chk(134, "p1_start",     mk(0, 1, 0, 1, 23, 0, 1, 0));
        add_chk(143, "p1_end",       mk(0, 1, 0, 1, 32, 0, 1, 0));
        add_chk(144, "n1_start",     mk(1, 0, 0, 1, 33, 0, 1, 0));
        add_chk(153, "n1_end",       mk(1, 0, 0, 1, 42, 0, 1, 0));
        add_chk(154, "burst_off",    mk(1, 1, 1, 1, 43, 0, 1, 0));
        add_chk(174, "last_write",   mk(1, 1, 1, 1, 63, 0, 1, 0));
        add_chk(175, "ready",        mk(1, 1, 1, 0, 0,  1, 1, 0));
        add_chk(300, "ready_hold",   mk(1, 1, 1, 0, 0,  1, 1, 0));
        add_chk(301, "readout_done", idle);
        add_chk(303, "shot2_charge", mk(1, 1, 0, 0, 0,  0, 1, 0));
        add_chk(403, "shot2_fire",   mk(0, 1, 0, 1, 0,  0, 1, 0));
        add_chk(407, "pre_abort",    mk(0, 1, 0, 1, 4,  0, 1, 0));
        add_chk(408, "aborted",      idle);
        add_chk(410, "abort_wins",   idle);
        add_chk(470, "no_ready",     idle);

        for (int c = 0; c <= 470; c++) begin
            apply_stimulus(c);
            check_output(c);
        end

        // Reset in the middle of capture.
        next_cycle(1, 0, 0, 0);
        s0 = cyc;
        repeat (101) next_cycle(0, 0, 0, 0);
        check_vec("rst_seq_fire", mk(0, 1, 0, 1, 0, 0, 1, 0));
        repeat (48) next_cycle(0, 0, 0, 0);
        next_cycle(0, 0, 0, 1);
        check_vec("pre_rst", mk(1, 1, 1, 1, 49, 0, 1, 0));
        next_cycle(0, 0, 0, 0);
        check_vec("rst_cleared", idle);
        next_cycle(0, 0, 0, 0);
        check_vec("rst_idle", idle);
        check_int("rst_seq_start", cyc - s0, 152);

        // Fresh shot after reset: full charge time and capture length.
        next_cycle(1, 0, 0, 0);
        s2 = cyc;
        n = 0;
        while (bus.ema_pulse_p !== 1'b0 && n < 200) begin
            next_cycle(0, 0, 0, 0);
            n++;
        end
        check_int("fire_latency", cyc - s2, 101);
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 200) begin
            next_cycle(0, 0, 0, 0);
            n++;
        end
        check_int("ready_latency", cyc - s2, 165);

        // start and rd_done together in READY, then an immediate new shot.
        next_cycle(1, 0, 1, 0);
        check_vec("ready_both", mk(1, 1, 1, 0, 0, 1, 1, 0));
        next_cycle(1, 0, 0, 0);
        check_vec("start_rd_same", mk(1, 1, 1, 0, 0, 0, 0, 1));
        next_cycle(0, 0, 0, 0);
        check_vec("back_to_back", mk(1, 1, 0, 0, 0, 0, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
